// File: rtl/bias_bank_controller.sv
// bias_bank_controller: ping-pong bias store for the squeeze/expand datapath.
// One bank is written with the next layer's biases while the other bank is
// replayed one word per MAC-array request, sweeping columns then groups.

// One lane of bias storage: DATA_W bits per entry, one write and one
// synchronous read port. The bank select is the address MSB.
module bias_lane_ram #(
    parameter int DATA_W = 8,
    parameter int AW     = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem [2**AW];

    // RAM array: contents carry no reset, the read register is only
    // meaningful when the controller flags it valid.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem[raddr_i];
    end
endmodule

module bias_bank_controller #(
    parameter int DATA_W = 8,
    parameter int LANES  = 8,
    parameter int GRP_W  = 7,
    parameter int DIM_W  = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic [GRP_W-1:0]        no_of_groups_i,
    input  logic [DIM_W-1:0]        layer_dimension_i,
    input  logic [LANES*DATA_W-1:0] wr_data_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    output logic                    load_done_o,
    input  logic                    release_i,
    output logic                    bank_ready_o,
    input  logic                    bias_req_i,
    output logic [LANES*DATA_W-1:0] bias_data_o,
    output logic                    bias_valid_o,
    output logic                    pass_done_o,
    output logic                    err_o
);
    localparam int AW = GRP_W + 1;

    localparam logic [1:0] L_IDLE = 2'd0;
    localparam logic [1:0] L_LOAD = 2'd1;
    localparam logic [1:0] L_FULL = 2'd2;

    logic [1:0]       state;
    logic             load_bank;
    logic             serve_bank;
    logic [GRP_W-1:0] ld_groups, wr_addr;
    logic [DIM_W-1:0] ld_dim;
    logic [GRP_W-1:0] sv_groups, rd_grp;
    logic [DIM_W-1:0] sv_dim, col_cnt;
    logic             bank_ready_q, bias_valid_q, pass_done_q, load_done_q, err_q;

    logic wr_fire, last_word, promote, rd_fire, col_wrap, grp_wrap;

    logic [LANES-1:0][DATA_W-1:0] wr_lanes;
    logic [LANES-1:0][DATA_W-1:0] rd_lanes;

    // Banks are always opposite, so reads and writes never hit the same bank.
    assign serve_bank = ~load_bank;

    // Handshake and counter terminal decodes. start_i overrides any write or
    // promotion that would otherwise happen in the same cycle.
    always_comb begin
        wr_fire   = (state == L_LOAD) && wr_valid_i && !start_i;
        last_word = (wr_addr == ld_groups);
        promote   = (state == L_FULL) && (!bank_ready_q || release_i) && !start_i;
        rd_fire   = bias_req_i && bank_ready_q;
        col_wrap  = (col_cnt == sv_dim);
        grp_wrap  = (rd_grp == sv_groups);
    end

    // Load FSM: latch config on start, count accepted words, wait full.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= L_IDLE;
            ld_groups   <= '0;
            ld_dim      <= '0;
            wr_addr     <= '0;
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= wr_fire && last_word;
            if (start_i) begin
                state     <= L_LOAD;
                ld_groups <= no_of_groups_i;
                ld_dim    <= layer_dimension_i;
                wr_addr   <= '0;
            end else if (wr_fire) begin
                if (last_word) state <= L_FULL;
                else           wr_addr <= wr_addr + 1'b1;
            end else if (promote) begin
                state <= L_IDLE;
            end
        end
    end

    // Bank swap: a full load bank becomes the serving bank once the old one
    // is released (or was never valid); release alone just invalidates.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            load_bank    <= 1'b0;
            bank_ready_q <= 1'b0;
            sv_groups    <= '0;
            sv_dim       <= '0;
        end else if (promote) begin
            load_bank    <= ~load_bank;
            bank_ready_q <= 1'b1;
            sv_groups    <= ld_groups;
            sv_dim       <= ld_dim;
        end else if (release_i) begin
            bank_ready_q <= 1'b0;
        end
    end

    // Serve counters: columns inner, groups outer; a promotion restarts the
    // sweep even if a request to the old bank is served in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col_cnt <= '0;
            rd_grp  <= '0;
        end else if (promote) begin
            col_cnt <= '0;
            rd_grp  <= '0;
        end else if (rd_fire) begin
            if (col_wrap) begin
                col_cnt <= '0;
                rd_grp  <= grp_wrap ? '0 : rd_grp + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Output flags track the one-cycle RAM read latency.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bias_valid_q <= 1'b0;
            pass_done_q  <= 1'b0;
        end else begin
            bias_valid_q <= rd_fire;
            pass_done_q  <= rd_fire && col_wrap && grp_wrap;
        end
    end

    // Sticky error for requests against an invalid bank; start clears it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                       err_q <= 1'b0;
        else if (start_i)                   err_q <= 1'b0;
        else if (bias_req_i && !bank_ready_q) err_q <= 1'b1;
    end

    assign wr_lanes = wr_data_i;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bias_lane_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
            .clk_i   (clk_i),
            .we_i    (wr_fire),
            .waddr_i ({load_bank, wr_addr}),
            .wdata_i (wr_lanes[l]),
            .re_i    (rd_fire),
            .raddr_i ({serve_bank, rd_grp}),
            .rdata_o (rd_lanes[l])
        );
    end

    // Data is masked to zero when not valid so reset clears it asynchronously.
    assign bias_data_o  = bias_valid_q ? rd_lanes : '0;
    assign bias_valid_o = bias_valid_q;
    assign pass_done_o  = pass_done_q;
    assign bank_ready_o = bank_ready_q;
    assign load_done_o  = load_done_q;
    assign wr_ready_o   = (state == L_LOAD);
    assign err_o        = err_q;
endmodule

// File: tb/tb_bias_bank_controller.sv
// Bench for bias_bank_controller: directed sequences, a vector table and a
// randomized phase, all checked against a queue-based reference model.
module tb_bias_bank_controller;
    localparam int DATA_W = 8, LANES = 8, GRP_W = 7, DIM_W = 7;
    localparam int W = LANES * DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic             start = 0, wvalid = 0, rel = 0, req = 0;
    logic [GRP_W-1:0] ngrp = '0;
    logic [DIM_W-1:0] ndim = '0;
    logic [W-1:0]     wdata = '0;
    logic             wr_ready, load_done, bank_ready, bvalid, pass_done, err;
    logic [W-1:0]     bdata;

    bias_bank_controller #(.DATA_W(DATA_W), .LANES(LANES), .GRP_W(GRP_W), .DIM_W(DIM_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .no_of_groups_i(ngrp), .layer_dimension_i(ndim),
        .wr_data_i(wdata), .wr_valid_i(wvalid), .wr_ready_o(wr_ready),
        .load_done_o(load_done), .release_i(rel), .bank_ready_o(bank_ready),
        .bias_req_i(req), .bias_data_o(bdata), .bias_valid_o(bvalid),
        .pass_done_o(pass_done), .err_o(err)
    );

    int checks = 0, failures = 0;

    // Reference model: banks as queues, serve position as a request count.
    bit           m_loading, m_full, m_ready, m_err, m_done, m_valid, m_pass;
    logic [W-1:0] m_data;
    int           m_ld_g, m_ld_d, m_sv_g, m_sv_d, m_req_n;
    logic [W-1:0] m_ld_q[$], m_sv_q[$];

    function automatic void model_reset();
        m_loading = 0; m_full = 0; m_ready = 0; m_err = 0; m_done = 0;
        m_valid = 0; m_pass = 0; m_data = '0;
        m_ld_g = 0; m_ld_d = 0; m_sv_g = 0; m_sv_d = 0; m_req_n = 0;
        m_ld_q.delete(); m_sv_q.delete();
    endfunction

    function automatic void model_step();
        bit promote;
        int grp, per;
        promote = !start && m_full && (!m_ready || rel);
        m_valid = 0; m_pass = 0; m_data = '0; m_done = 0;
        if (req) begin
            if (m_ready) begin
                per = (m_sv_g + 1) * (m_sv_d + 1);
                grp = (m_req_n / (m_sv_d + 1)) % (m_sv_g + 1);
                m_data  = m_sv_q[grp];
                m_valid = 1;
                m_pass  = ((m_req_n + 1) % per) == 0;
                m_req_n++;
            end else begin
                m_err = 1;
            end
        end
        if (start) begin
            m_loading = 1; m_full = 0; m_ld_q.delete();
            m_ld_g = int'(ngrp); m_ld_d = int'(ndim); m_err = 0;
        end else if (m_loading && wvalid) begin
            m_ld_q.push_back(wdata);
            if (m_ld_q.size() == m_ld_g + 1) begin
                m_loading = 0; m_full = 1; m_done = 1;
            end
        end
        if (promote) begin
            m_sv_q = m_ld_q; m_sv_g = m_ld_g; m_sv_d = m_ld_d;
            m_ready = 1; m_req_n = 0; m_full = 0;
        end else if (rel) begin
            m_ready = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("wr_ready",   W'(wr_ready),   W'(m_loading));
        chk("load_done",  W'(load_done),  W'(m_done));
        chk("bank_ready", W'(bank_ready), W'(m_ready));
        chk("bias_valid", W'(bvalid),     W'(m_valid));
        chk("bias_data",  bdata,          m_data);
        chk("pass_done",  W'(pass_done),  W'(m_pass));
        chk("err",        W'(err),        W'(m_err));
    endtask

    // One clock: model sees the same inputs the DUT samples; pulses then drop.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        start = 0; rel = 0; req = 0; wvalid = 0;
    endtask

    task automatic do_start(input int g, input int d);
        start = 1; ngrp = GRP_W'(g); ndim = DIM_W'(d);
        cycle();
    endtask

    function automatic logic [W-1:0] mkw(input logic [7:0] tag, input int i);
        logic [W-1:0] w;
        for (int l = 0; l < LANES; l++) w[l*8 +: 8] = tag + 8'(i * 16 + l);
        return w;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_ready"},   W'(wr_ready),   '0);
        chk({tag, "_load_done"},  W'(load_done),  '0);
        chk({tag, "_bank_ready"}, W'(bank_ready), '0);
        chk({tag, "_bias_valid"}, W'(bvalid),     '0);
        chk({tag, "_bias_data"},  bdata,          '0);
        chk({tag, "_pass_done"},  W'(pass_done),  '0);
        chk({tag, "_err"},        W'(err),        '0);
    endtask

    typedef struct {
        bit req;
        bit exp_valid;
        int exp_idx;
        bit exp_pass;
    } vec_t;

    logic [W-1:0] A[4], B[2], C[4], D[2];
    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bit done;
        for (int i = 0; i < 4; i++) begin
            A[i] = mkw(8'hA0, i); C[i] = mkw(8'h30, i);
        end
        for (int i = 0; i < 2; i++) begin
            B[i] = mkw(8'hB0, i); D[i] = mkw(8'h50, i);
        end
        for (int i = 0; i < 9; i++) tbl[i] = '{1, 1, (i % 8) / 2, i == 7};
        tbl[9] = '{0, 0, 0, 0};

        // Reset state
        model_reset();
        #1 rst_n = 0;
        #1 chk_all_zero("reset");
        #10 rst_n = 1;

        // Request with no valid bank: no data, sticky error, start clears it
        req = 1; cycle();
        chk("noload_valid", W'(bvalid), '0);
        chk("noload_err", W'(err), 1);
        cycle();
        chk("err_sticky", W'(err), 1);
        do_start(3, 1);
        chk("start_clears_err", W'(err), '0);
        chk("start_wr_ready", W'(wr_ready), 1);

        // Load A0..A3, groups=3 dim=1
        for (int i = 0; i < 4; i++) begin
            wvalid = 1; wdata = A[i]; cycle();
        end
        chk("A_load_done", W'(load_done), 1);
        chk("A_not_ready_yet", W'(bank_ready), '0);
        cycle();
        chk("A_bank_ready", W'(bank_ready), 1);
        chk("A_done_pulse", W'(load_done), '0);

        // Table: back-to-back requests replay A0,A0,A1,A1,...,A3 then A0
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req; cycle();
            chk("tbl_valid", W'(bvalid), W'(tbl[i].exp_valid));
            chk("tbl_data", bdata, tbl[i].exp_valid ? A[tbl[i].exp_idx] : '0);
            chk("tbl_pass", W'(pass_done), W'(tbl[i].exp_pass));
        end

        // Load B while A serves: waits full, A still served, release swaps
        do_start(1, 0);
        wvalid = 1; wdata = B[0]; cycle();
        wvalid = 1; wdata = B[1]; cycle();
        cycle();
        chk("B_full_wr_ready", W'(wr_ready), '0);
        req = 1; cycle();
        chk("B_still_A", bdata, A[0]);
        rel = 1; cycle();
        chk("B_swap_no_gap", W'(bank_ready), 1);
        req = 1; cycle(); chk("B_rd0", bdata, B[0]);
        req = 1; cycle(); chk("B_rd1", bdata, B[1]);
        chk("B_pass", W'(pass_done), 1);
        req = 1; cycle(); chk("B_rd2", bdata, B[0]);

        // 128-word load with random write stalls, then full readback
        do_start(127, 0);
        done = 0;
        for (int n = 0; n < 2000 && !done; n++) begin
            wvalid = 1'($urandom_range(0, 1));
            wdata = {$urandom, $urandom};
            cycle();
            done = m_full;
        end
        chk("load128_completes", W'(done), 1);
        rel = 1; cycle();
        for (int i = 0; i < 129; i++) begin
            req = 1; cycle();
        end

        // Aborted load: restart after 2 words, only C must be served
        do_start(3, 0);
        wvalid = 1; wdata = mkw(8'hEE, 0); cycle();
        wvalid = 1; wdata = mkw(8'hEE, 1); cycle();
        do_start(3, 0);
        for (int i = 0; i < 4; i++) begin
            wvalid = 1; wdata = C[i]; cycle();
        end
        rel = 1; cycle();
        for (int i = 0; i < 8; i++) begin
            req = 1; cycle();
            chk("C_data", bdata, C[i % 4]);
        end

        // Asynchronous reset mid-pass with a load in flight
        start = 1; ngrp = 7'd1; ndim = 7'd1; req = 1; cycle();
        #2 rst_n = 0;
        #1 chk_all_zero("midreset");
        model_reset();
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1;

        // Fresh load and serve after reset: D groups=1 dim=1
        do_start(1, 1);
        for (int i = 0; i < 2; i++) begin
            wvalid = 1; wdata = D[i]; cycle();
        end
        cycle();
        for (int i = 0; i < 4; i++) begin
            req = 1; cycle();
            chk("D_data", bdata, D[i / 2]);
        end
        chk("D_pass", W'(pass_done), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 59) == 0);
            ngrp = GRP_W'($urandom_range(0, 7));
            ndim = DIM_W'($urandom_range(0, 3));
            wvalid = ($urandom_range(0, 3) != 0);
            wdata = {$urandom, $urandom};
            rel = ($urandom_range(0, 24) == 0);
            req = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bias_bank_controller.md
# bias_bank_controller

Double-buffered bias store for the squeeze/expand convolution datapath. It accepts packed bias words for the next layer on a valid/ready stream while the current layer's biases are being served. It replays one bias group per output-pixel row sweep, as the MAC array requests them. It generalises the single-bank bash controller with parametrised width, lanes and depth, ping-pong banks, and explicit handshakes.

## Interface
- DATA_W, 8, bits per bias
- LANES, 8, biases per RAM word (one per parallel kernel lane)
- GRP_W, 7, group address width; bank depth 2**GRP_W groups
- DIM_W, 7, layer-dimension counter width
- clk_i  in  1  clock; one clock domain
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse: latch load config, begin loading the load bank
- no_of_groups_i  in  GRP_W  kernel groups − 1
- layer_dimension_i  in  DIM_W  columns per group − 1
- wr_data_i  in  LANES*DATA_W  packed biases; lane 0 in LSBs
- wr_valid_i  in  1  write word valid
- wr_ready_o  out  1  accepting writes
- load_done_o  out  1  one-cycle pulse when the last word is accepted
- release_i  in  1  pulse: serving layer finished, serving bank may be replaced
- bank_ready_o  out  1  serving bank valid
- bias_req_i  in  1  request one bias word
- bias_data_o  out  LANES*DATA_W  bias word
- bias_valid_o  out  1  bias_data_o valid
- pass_done_o  out  1  with bias_valid_o of the final (group, column) of a pass
- err_o  out  1  sticky: bias_req_i seen while bank_ready_o = 0; cleared by start_i

## Operation
- Storage: 2 × 2**GRP_W words of LANES*DATA_W, synchronous read. load_bank and serve_bank are always opposite, so there are no read/write collisions.
- Load FSM states: L_IDLE, L_LOAD, L_FULL.
  - L_IDLE/L_LOAD/L_FULL + start_i → L_LOAD. Latches ld_groups and ld_dim, clears wr_addr, clears err_o. A partial or full unpromoted load is discarded.
  - L_LOAD: wr_ready_o = 1. On wr_valid_i & wr_ready_o, write mem[load_bank][wr_addr] and increment wr_addr. When wr_addr == ld_groups, pulse load_done_o and go to L_FULL.
  - L_FULL with (bank_ready_o = 0 or release_i): promote. serve_bank ← load_bank; load_bank toggles; sv_groups/sv_dim ← ld_*; bank_ready_o ← 1; serve counters cleared; go to L_IDLE.
  - release_i without promotion: bank_ready_o ← 0.
- Serve side (only while bank_ready_o):
  - Each bias_req_i reads mem[serve_bank][rd_grp].
  - col_cnt increments and wraps at sv_dim. On wrap, rd_grp increments, wrapping to 0 after sv_groups. Passes repeat until release_i.
  - bias_req_i while bank_ready_o = 0: ignored, no valid, err_o ← 1.
- Arithmetic: counters are unsigned, with no overflow beyond configured terminal values. no_of_groups_i = 0 means a single group; layer_dimension_i = 0 means one column per group.

## Timing
- Reset values: wr_ready_o 0, load_done_o 0, bank_ready_o 0, bias_valid_o 0, bias_data_o 0, pass_done_o 0, err_o 0. FSM is L_IDLE, banks: load 0 / serve 1. The asynchronous assert clears everything mid-operation, and RAM contents are don't-care afterwards.
- start_i at edge t: wr_ready_o high from t+1.
- Last write accepted at edge t: load_done_o high during t+1, state is L_FULL. If the serving bank is empty, bank_ready_o rises at t+2.
- Read latency is 1: bias_req_i at edge t gives bias_valid_o and bias_data_o during t+1. The group advance takes effect for the next request (request-to-request, back-to-back legal).
- release_i with a bias_req_i in the same cycle: the request is served from the old bank and release takes effect after.
- release_i and L_FULL in the same cycle: promotion occurs at that edge, and bank_ready_o stays 1 without a gap.
- start_i and a write in the same cycle: start_i wins and the write is dropped (wr_ready_o was already required to be sampled with the old state; the bench must not rely on acceptance).

## Test plan
- Reset, then start_i with groups=3 and dim=1. Write 4 words A0..A3 → load_done_o on the 4th acceptance; bank_ready_o 1 cycle later. 8 back-to-back requests → A0,A0,A1,A1,A2,A2,A3,A3, pass_done_o on the 8th valid, then A0 again.
- While serving A, load B (groups=1, dim=0) → state stays L_FULL, wr_ready_o 0, output still A. Pulse release_i → the next request returns B0, then B1, B0.
- Stall wr_valid_i randomly during a load of 128 words (groups=127) → all words stored in order. Readback with dim=0 matches.
- bias_req_i before any load → no bias_valid_o, err_o = 1. start_i clears err_o.
- start_i mid-load after 2 of 4 words, then reload C0..C3 → only C served. No stale data.
- Assert rst_n_i low mid-pass → all outputs 0 asynchronously. After release, a fresh load/serve works.
